// File: rtl/joybus_tx_multi_if.sv
// Command/line bundle between the sequencer, the JoyBus transmitter and the pad mux.
// slave is the transmitter's view; master is the sequencer/pad side.
interface joybus_tx_multi_if #(
  parameter int MAX_BYTES = 3
);
  localparam int LEN_W = $clog2(MAX_BYTES + 1);

  logic [8*MAX_BYTES-1:0] cmd_data;
  logic [LEN_W-1:0]       cmd_len;
  logic                   cmd_rdy;
  logic                   rx_done;
  logic                   JB_TX;
  logic                   JB_TX_SEL;
  logic                   busy;
  logic                   tx_done;
  logic                   cmd_err;
  logic                   rx_timeout;

  modport master (
    output cmd_data, cmd_len, cmd_rdy, rx_done,
    input  JB_TX, JB_TX_SEL, busy, tx_done, cmd_err, rx_timeout
  );

  modport slave (
    input  cmd_data, cmd_len, cmd_rdy, rx_done,
    output JB_TX, JB_TX_SEL, busy, tx_done, cmd_err, rx_timeout
  );
endinterface

// File: rtl/joybus_tx_multi.sv
// Host-side JoyBus transmitter: serialises 1..MAX_BYTES command bytes plus stop bit, then hands the line to rx.
// Optional RX_WAIT timeout is enabled with the macro JOYBUS_TX_TIMEOUT_EN.
module joybus_tx_multi #(
  parameter int US_CYC         = 24,
  parameter int MAX_BYTES      = 3,
  parameter int RX_TIMEOUT_CYC = 4800
) (
  input  logic              clk,
  input  logic              rst,
  joybus_tx_multi_if.slave  bus
);
  localparam int FRAME_W  = 8 * MAX_BYTES;
  localparam int LEN_W    = $clog2(MAX_BYTES + 1);
  localparam int IDX_W    = LEN_W + 3;
  localparam int CNT_SPAN = (3 * US_CYC > RX_TIMEOUT_CYC) ? 3 * US_CYC : RX_TIMEOUT_CYC;
  localparam int CNT_W    = $clog2(CNT_SPAN);

  localparam logic [CNT_W-1:0] T_1US = CNT_W'(US_CYC - 1);
  localparam logic [CNT_W-1:0] T_2US = CNT_W'(2 * US_CYC - 1);
  localparam logic [CNT_W-1:0] T_3US = CNT_W'(3 * US_CYC - 1);
`ifdef JOYBUS_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] T_RX  = CNT_W'(RX_TIMEOUT_CYC - 1);
`endif

  typedef enum logic [2:0] {IDLE, BIT_LO, BIT_HI, STOP_LO, STOP_HI, RX_WAIT} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [FRAME_W-1:0]   sreg, frame_in;
  logic [LEN_W-1:0]     len_q;
  logic                 accept, shift, done, err;
  logic                 line_q, sel_q, busy_q, done_q, err_q;

  // Phase lengths are loaded as (cycles - 1) and the phase ends when the counter reaches zero.
  function automatic logic [CNT_W-1:0] lo_len(input logic b);
    return b ? T_1US : T_3US;
  endfunction

  function automatic logic [CNT_W-1:0] hi_len(input logic b);
    return b ? T_3US : T_1US;
  endfunction

  // Byte 0 lands in the top byte so a left shift emits byte 0 first, MSB first.
  always_comb begin
    frame_in = '0;
    for (int i = 0; i < MAX_BYTES; i++)
      frame_in[FRAME_W-8-8*i +: 8] = bus.cmd_data[8*i +: 8];
  end

`ifdef JOYBUS_TX_TIMEOUT_EN
  logic tmo, tmo_q;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? '0 : cnt - CNT_W'(1);
    idx_nxt   = idx;
    accept    = 1'b0;
    shift     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
`ifdef JOYBUS_TX_TIMEOUT_EN
    tmo       = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (bus.cmd_rdy) begin
          if (bus.cmd_len != '0 && bus.cmd_len <= LEN_W'(MAX_BYTES)) begin
            accept    = 1'b1;
            idx_nxt   = '0;
            cnt_nxt   = lo_len(bus.cmd_data[7]);
            state_nxt = BIT_LO;
          end else begin
            err = 1'b1;
          end
        end
      end
      BIT_LO: if (cnt == '0) begin
        cnt_nxt   = hi_len(sreg[FRAME_W-1]);
        state_nxt = BIT_HI;
      end
      BIT_HI: if (cnt == '0) begin
        if (idx == ({len_q, 3'b000} - IDX_W'(1))) begin
          cnt_nxt   = T_1US;
          state_nxt = STOP_LO;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          shift     = 1'b1;
          cnt_nxt   = lo_len(sreg[FRAME_W-2]);
          state_nxt = BIT_LO;
        end
      end
      STOP_LO: if (cnt == '0) begin
        cnt_nxt   = T_2US;
        state_nxt = STOP_HI;
      end
      STOP_HI: if (cnt == '0) begin
        done      = 1'b1;
`ifdef JOYBUS_TX_TIMEOUT_EN
        cnt_nxt   = T_RX;
`else
        cnt_nxt   = '0;
`endif
        state_nxt = RX_WAIT;
      end
      RX_WAIT: begin
        if (bus.rx_done) begin
          state_nxt = IDLE;
`ifdef JOYBUS_TX_TIMEOUT_EN
        end else if (cnt == '0) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      line_q <= 1'b1;
      sel_q  <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      line_q <= !(state_nxt == BIT_LO || state_nxt == STOP_LO);
      sel_q  <= (state_nxt != RX_WAIT);
      busy_q <= (state_nxt != IDLE);
      done_q <= done;
      err_q  <= err;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sreg  <= frame_in;
      len_q <= bus.cmd_len;
    end else if (shift) begin
      sreg  <= {sreg[FRAME_W-2:0], 1'b0};
    end
  end

`ifdef JOYBUS_TX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= 1'b0;
    else     tmo_q <= tmo;
  end
  assign bus.rx_timeout = tmo_q;
`else
  assign bus.rx_timeout = 1'b0;
`endif

  assign bus.JB_TX     = line_q;
  assign bus.JB_TX_SEL = sel_q;
  assign bus.busy      = busy_q;
  assign bus.tx_done   = done_q;
  assign bus.cmd_err   = err_q;
endmodule

// File: tb/tb_joybus_tx_multi.sv
// Scoreboarded bench for joybus_tx_multi: line symbols and frame lengths are predicted at send time
// and checked by a line monitor as the DUT emits them.
module tb_joybus_tx_multi;
  localparam int US  = 24;
  localparam int MB  = 3;
  localparam int LW  = $clog2(MB + 1);
  localparam int RXT = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;

  joybus_tx_multi_if #(.MAX_BYTES(MB)) bus ();
  joybus_tx_multi_if #(.MAX_BYTES(2))  bus2 ();

  joybus_tx_multi #(.US_CYC(US), .MAX_BYTES(MB), .RX_TIMEOUT_CYC(RXT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  joybus_tx_multi #(.US_CYC(US), .MAX_BYTES(2), .RX_TIMEOUT_CYC(RXT)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  always #5 clk = ~clk;

  typedef struct { int lo; int hi; } sym_t;
  sym_t exp_sym_q[$];
  int   exp_len_q[$];

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sym_done(input int lo, input int hi);
    sym_t e;
    if (exp_sym_q.size() == 0) begin
      check("sym_unexpected", 1, 0);
    end else begin
      e = exp_sym_q.pop_front();
      check("sym_lo", lo, e.lo);
      check("sym_hi", hi, e.hi);
    end
  endtask

  // Line monitor: measures each low/high run while tx owns the line.
  int cyc = 0, t_first = 0, lo_n = 0, hi_n = 0, phase = 0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      phase = 0; lo_n = 0; hi_n = 0;
    end else begin
      if (bus.JB_TX_SEL && !bus.JB_TX) begin
        if (phase == 2) sym_done(lo_n, hi_n);
        if (phase == 0) t_first = cyc;
        if (phase != 1) lo_n = 0;
        phase = 1;
        lo_n++;
      end else if (bus.JB_TX_SEL && phase != 0) begin
        if (phase == 1) hi_n = 0;
        phase = 2;
        hi_n++;
      end else if (!bus.JB_TX_SEL) begin
        if (phase == 2) sym_done(lo_n, hi_n);
        phase = 0;
      end
      if (bus.tx_done) begin
        if (exp_len_q.size() == 0) check("tx_done_unexpected", 1, 0);
        else check("frame_len", cyc - t_first, exp_len_q.pop_front());
      end
    end
  end

  task automatic send(input logic [8*MB-1:0] data, input int len);
    logic b;
    for (int i = 0; i < len; i++)
      for (int j = 7; j >= 0; j--) begin
        b = data[8*i+j];
        exp_sym_q.push_back('{b ? US : 3*US, b ? 3*US : US});
      end
    exp_sym_q.push_back('{US, 2*US});
    exp_len_q.push_back(32*len*US + 3*US);
    bus.cmd_data = data;
    bus.cmd_len  = LW'(len);
    bus.cmd_rdy  = 1'b1;
    @(negedge clk);
    bus.cmd_rdy  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit busy_drop);
    bit ok = 0;
    busy_drop = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.tx_done) begin ok = 1; break; end
      if (!bus.busy) busy_drop = 1;
    end
    check("tx_done_seen", ok, 1);
    check("done_sel", bus.JB_TX_SEL, 0);
    check("done_tx", bus.JB_TX, 1);
    check("done_busy", bus.busy, 1);
  endtask

  task automatic rx_release(input int delay);
    repeat (delay) @(negedge clk);
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    check("rel_sel", bus.JB_TX_SEL, 1);
    check("rel_busy", bus.busy, 0);
    check("rel_tx", bus.JB_TX, 1);
  endtask

  task automatic err_req(input int which, input int len);
    if (which == 0) begin
      bus.cmd_len = LW'(len); bus.cmd_rdy = 1'b1;
    end else begin
      bus2.cmd_len = 2'(len); bus2.cmd_rdy = 1'b1;
    end
    @(negedge clk);
    bus.cmd_rdy = 1'b0; bus2.cmd_rdy = 1'b0;
    check("err_pulse", which == 0 ? bus.cmd_err : bus2.cmd_err, 1);
    check("err_busy", which == 0 ? bus.busy : bus2.busy, 0);
    check("err_tx", which == 0 ? bus.JB_TX : bus2.JB_TX, 1);
    @(negedge clk);
    check("err_once", which == 0 ? bus.cmd_err : bus2.cmd_err, 0);
    check("err_tx_hold", which == 0 ? bus.JB_TX : bus2.JB_TX, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit drop;
    bit seen;
    int k;
    bus.cmd_data = '0; bus.cmd_len = '0; bus.cmd_rdy = 1'b0; bus.rx_done = 1'b0;
    bus2.cmd_data = '0; bus2.cmd_len = '0; bus2.cmd_rdy = 1'b0; bus2.rx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.JB_TX, 1);
    check("rst_sel", bus.JB_TX_SEL, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.tx_done, 0);
    check("rst_err", bus.cmd_err, 0);
    check("rst_tmo", bus.rx_timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single zero byte, then RX_WAIT with an ignored request and a late rx_done.
    send(24'h000000, 1);
    wait_done(1200, drop);
    @(negedge clk);
    check("tx_done_once", bus.tx_done, 0);
    repeat (40) @(negedge clk);
    bus.cmd_data = 24'h0000FF; bus.cmd_len = LW'(1); bus.cmd_rdy = 1'b1;
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    check("rxwait_sel", bus.JB_TX_SEL, 0);
    rx_release(58);
    repeat (20) @(negedge clk);
    check("rdy_ignored", bus.busy, 0);

    // Three-byte frame.
    send({8'h03, 8'h02, 8'h01}, 3);
    wait_done(3000, drop);
    check("busy_thru", drop, 0);
    check("tmo_quiet", bus.rx_timeout, 0);
    rx_release(5);

    // Rejected lengths.
    err_req(0, 0);
    err_req(1, 0);
    err_req(1, 3);

    // Reset in the middle of a 0xFF frame.
    send(24'h0000FF, 1);
    repeat (149) @(negedge clk);
    rst = 1'b1;
    exp_sym_q.delete();
    exp_len_q.delete();
    @(negedge clk);
    check("midrst_tx", bus.JB_TX, 1);
    check("midrst_sel", bus.JB_TX_SEL, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.tx_done, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (900) begin
      @(negedge clk);
      if (bus.tx_done || bus.busy) seen = 1;
    end
    check("midrst_quiet", seen, 0);
    send({8'h00, 8'hC3, 8'h5A}, 2);
    wait_done(2000, drop);
    check("busy_thru2", drop, 0);
    rx_release(3);

`ifdef JOYBUS_TX_TIMEOUT_EN
    send(24'h000080, 1);
    wait_done(1200, drop);
    k = 0;
    for (int i = 1; i <= RXT + 10; i++) begin
      @(negedge clk);
      if (bus.rx_timeout) begin k = i; break; end
    end
    check("tmo_cycles", k, RXT);
    check("tmo_busy", bus.busy, 0);
    check("tmo_sel", bus.JB_TX_SEL, 1);
    @(negedge clk);
    check("tmo_once", bus.rx_timeout, 0);

    send(24'h000081, 1);
    wait_done(1200, drop);
    repeat (RXT - 1) @(negedge clk);
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    check("tmo_race_pulse", bus.rx_timeout, 0);
    check("tmo_race_busy", bus.busy, 0);
`endif

    repeat (5) @(negedge clk);
    check("sb_empty", exp_sym_q.size() + exp_len_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
